// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed hex seven-segment driver for common-anode displays.
// Shadow-registered data, per-digit blank/dp, optional leading-zero suppression.
module sevseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_SUPPRESS = 1,
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [0:6]              ca,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDXW-1:0]         digit_idx
);

    localparam int CNTW = $clog2(REFRESH_DIV);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(REFRESH_DIV - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [CNTW-1:0]         cnt;
    logic                    tick;
    logic                    upd;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    allz;
    logic [3:0]              nib;
    logic                    dpsel;
    logic                    dark;
    logic [0:6]              seg;
    logic [NUM_DIGITS-1:0]   an_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
        end else if (load) begin
            sh_value <= value;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
        end
    end

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            digit_idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNTW'(1);
            if (tick)
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDXW'(1);
        end
    end

    // Scan from the most significant digit down: a digit is suppressed
    // while every nibble at or above it is zero.
    always_comb begin
        allz = 1'b1;
        supp = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            allz = allz & (sh_value[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
            supp[NUM_DIGITS-1-i] = allz;
        end
        supp[0] = 1'b0;
        if (LZ_SUPPRESS == 0)
            supp = '0;
    end

    always_comb begin
        nib    = 4'h0;
        dpsel  = 1'b0;
        dark   = 1'b0;
        an_nxt = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDXW'(i)) begin
                nib       = sh_value[4*i +: 4];
                dpsel     = sh_dp[i];
                dark      = sh_blank[i] | supp[i];
                an_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
    end

    // Outputs are refreshed only on the first cycle of each digit period, so a
    // digit's pattern stays frozen for its whole slot even if load fires mid-slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd <= 1'b1;
            an  <= '1;
            ca  <= '1;
            dp  <= 1'b1;
        end else begin
            upd <= tick;
            if (upd) begin
                an <= an_nxt;
                ca <= dark ? 7'b1111111 : seg;
                dp <= dark | ~dpsel;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Bench for sevseg_scan_driver: four builds (4 digits LZ on/off, 1 digit, 8 digits)
// compared every cycle against a closed-form time-based display model.
module tb_sevseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] vval = '0;
    logic [7:0]  vdp = '0;
    logic [7:0]  vblank = '0;

    logic [0:6] ca_a, ca_b, ca_c, ca_d;
    logic       dp_a, dp_b, dp_c, dp_d;
    logic [3:0] an_a, an_b;
    logic [0:0] an_c;
    logic [7:0] an_d;
    logic [1:0] idx_a, idx_b;
    logic [0:0] idx_c;
    logic [2:0] idx_d;

    always #5 clk = ~clk;

    sevseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_SUPPRESS(1)) dut_a (
        .clk(clk), .rst(rst), .value(vval[15:0]), .dp_in(vdp[3:0]), .blank_in(vblank[3:0]),
        .load(load), .ca(ca_a), .dp(dp_a), .an(an_a), .digit_idx(idx_a));
    sevseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_SUPPRESS(0)) dut_b (
        .clk(clk), .rst(rst), .value(vval[15:0]), .dp_in(vdp[3:0]), .blank_in(vblank[3:0]),
        .load(load), .ca(ca_b), .dp(dp_b), .an(an_b), .digit_idx(idx_b));
    sevseg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(3), .LZ_SUPPRESS(1)) dut_c (
        .clk(clk), .rst(rst), .value(vval[3:0]), .dp_in(vdp[0:0]), .blank_in(vblank[0:0]),
        .load(load), .ca(ca_c), .dp(dp_c), .an(an_c), .digit_idx(idx_c));
    sevseg_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(2), .LZ_SUPPRESS(1)) dut_d (
        .clk(clk), .rst(rst), .value(vval), .dp_in(vdp), .blank_in(vblank),
        .load(load), .ca(ca_d), .dp(dp_d), .an(an_d), .digit_idx(idx_d));

    int unsigned rdv [4] = '{4, 4, 3, 2};
    int unsigned nv  [4] = '{4, 4, 1, 8};
    int unsigned lzv [4] = '{1, 0, 1, 1};

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int tests = 0;
    int fails = 0;

    // Model: edges since reset release, the latest loaded data, and the data
    // each build latched at the start of its current digit slot.
    int unsigned t = 0;
    logic [31:0] m_val = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_blank = '0;
    logic [31:0] s_val [4];
    logic [7:0]  s_dp [4];
    logic [7:0]  s_blank [4];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d t=%0d observed=%h expected=%h", tag, d, t, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] oan, oca, odp, oidx;
        logic [31:0] ean, eca, edp, eidx;
        logic [63:0] v, vk;
        int unsigned n, k, p;
        bit sup, dark;
        for (int d = 0; d < 4; d++) begin
            case (d)
                0: begin oan = 32'(an_a); oca = 32'(ca_a); odp = 32'(dp_a); oidx = 32'(idx_a); end
                1: begin oan = 32'(an_b); oca = 32'(ca_b); odp = 32'(dp_b); oidx = 32'(idx_b); end
                2: begin oan = 32'(an_c); oca = 32'(ca_c); odp = 32'(dp_c); oidx = 32'(idx_c); end
                default: begin oan = 32'(an_d); oca = 32'(ca_d); odp = 32'(dp_d); oidx = 32'(idx_d); end
            endcase
            n = nv[d];
            if (rst || t == 0) begin
                ean = 32'((64'd1 << n) - 1);
                eca = 32'h7F;
                edp = 32'd1;
                eidx = 32'd0;
            end else begin
                p = (t - 1) / rdv[d];
                k = p % n;
                v = 64'(s_val[d]) & ((64'd1 << (4 * n)) - 1);
                vk = v >> (4 * k);
                sup = (lzv[d] != 0) && (k != 0) && (vk == 0);
                dark = s_blank[d][k] || sup;
                eca = dark ? 32'h7F : 32'(seg_tab[vk[3:0]]);
                edp = (dark || !s_dp[d][k]) ? 32'd1 : 32'd0;
                ean = 32'(((64'd1 << n) - 1) & ~(64'd1 << k));
                eidx = 32'((t / rdv[d]) % n);
            end
            chk("an", d, oan, ean);
            chk("ca", d, oca, eca);
            chk("dp", d, odp, edp);
            chk("digit_idx", d, oidx, eidx);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            t = 0;
            m_val = '0; m_dp = '0; m_blank = '0;
        end else begin
            t++;
            for (int d = 0; d < 4; d++) begin
                if ((t - 1) % rdv[d] == 0) begin
                    s_val[d] = m_val; s_dp[d] = m_dp; s_blank[d] = m_blank;
                end
            end
            if (load) begin
                m_val = vval; m_dp = vdp; m_blank = vblank;
            end
        end
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_once(input logic [31:0] v, input logic [7:0] dpv, input logic [7:0] bl);
        vval = v; vdp = dpv; vblank = bl; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            s_val[d] = '0; s_dp[d] = '0; s_blank[d] = '0;
        end
        run(3);
        rst = 1'b0;
        run(20);

        load_once(32'h89AB_12AF, 8'h00, 8'h00);
        run(40);
        load_once(32'h0000_0050, 8'h00, 8'h00);
        run(40);
        load_once(32'h0000_0000, 8'h00, 8'h00);
        run(40);
        load_once(32'h8888_8888, 8'h12, 8'h04);
        run(40);

        // Load of all-F landing exactly on a 4-digit tick edge while zeros show.
        load_once(32'h0000_0000, 8'h00, 8'h00);
        run(9);
        while (t % 4 != 3) cycle();
        load_once(32'hFFFF_FFFF, 8'h00, 8'h00);
        run(24);
        vval = 32'h1234_5678; vdp = 8'hFF; vblank = 8'hFF;
        run(24);

        load = 1'b1;
        for (int i = 0; i < 30; i++) begin
            vval = $urandom; vdp = 8'($urandom); vblank = 8'h00;
            cycle();
        end
        load = 1'b0;

        for (int i = 0; i < 300; i++) begin
            load = ($urandom_range(3) == 0);
            vval = $urandom >> $urandom_range(31);
            vdp = 8'($urandom);
            vblank = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            cycle();
        end
        load = 1'b0;

        // Asynchronous reset in the middle of a digit slot.
        load_once(32'h0000_12AF, 8'h00, 8'h00);
        run(6);
        #2;
        rst = 1'b1;
        t = 0; m_val = '0; m_dp = '0; m_blank = '0;
        #1;
        check_all();
        run(2);
        rst = 1'b0;
        run(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
- Time-multiplexed N-digit hexadecimal seven-segment display driver for the board's common-anode displays.
- Captures a packed hex word into a shadow register on `load` and scans one digit per refresh period.
- Drives active-low segment (`ca`), decimal-point (`dp`) and anode (`an`) lines.
- Adds per-digit blanking, decimal points and optional leading-zero suppression.
- Sits between the floating-point adder result registers and the board pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000: clk cycles each digit stays lit; legal range >=2.
- LZ_SUPPRESS, 1: 1 = blank leading zero digits; 0 = show all digits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble k = value[4k+3:4k]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit; 1 = lit.
- blank_in  in  NUM_DIGITS  force digit dark; 1 = blank.
- load  in  1  capture value/dp_in/blank_in into the shadow registers this cycle.
- ca  out  7 [0:6]  segments a..g, ca[0]=a, ca[6]=g; active low.
- dp  out  1  decimal point; active low.
- an  out  NUM_DIGITS  anode enables; active low, one-hot-zero.
- digit_idx  out  clog2(NUM_DIGITS) (min 1)  index of the digit currently driven.

Behaviour:
- Reset (async assert, sync release):
  - shadow registers = 0; prescaler = 0; digit_idx = 0.
  - an = all 1; ca = 7'b1111111; dp = 1.
- Shadow load:
  - When `load`=1 at a rising edge, value/dp_in/blank_in are registered.
  - The display uses only shadow contents, so scanning never tears.
  - `load` held high updates the shadow every cycle.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - The wrap cycle produces `tick`.
- Digit index:
  - On `tick`, digit_idx increments.
  - From NUM_DIGITS-1 it wraps to 0.
  - With NUM_DIGITS=1, digit_idx stays 0.
- Decode (nibble -> ca[0:6], active low, fixed):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit k is suppressed when all shadow nibbles k..NUM_DIGITS-1 are zero.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Suppression is computed from the shadow registers only.
- Digit output for digit k:
  - Dark if blank(k) or suppressed(k): ca = 1111111 and dp = 1.
  - The anode is still asserted while dark.
  - A dark digit ignores dp(k), so blanking dominates the decimal point.
- Outputs are registered:
  - an, ca and dp reflect digit_idx one cycle after digit_idx changes.
  - an[digit_idx_prev] = 0 and all other an bits = 1.
  - The first digit drives on the cycle after reset release.
- Load/tick collision: a `load` on the same edge as `tick` is used by the next digit's output, one cycle later. No glitch; old and new data are never mixed within one digit.
- Reset mid-scan: returns immediately to the reset state. Scanning restarts at digit 0 with an empty shadow, so the display shows "0" on digit 0 (LZ on).

Test Plan:
- Reset:
  - Stimulus: assert rst mid-scan with REFRESH_DIV=4, NUM_DIGITS=4.
  - Required: an=4'b1111, ca=1111111, dp=1 in the same cycle; after release the first displayed digit is idx 0 with ca=0000001.
- Scan timing:
  - Stimulus: REFRESH_DIV=4; load value=16'h12AF.
  - Required: an cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, each held exactly 4 clk.
  - Required: ca per digit = 0111000 (F), 0001000 (A), 0010010 (2), 1001111 (1).
- Leading zeros:
  - Stimulus: value=16'h0050, LZ_SUPPRESS=1.
  - Required: digit0 = 0000001, digit1 = 0100100, digits 2-3 = 1111111.
  - Stimulus: value=16'h0000. Required: only digit0 shows 0000001.
  - Stimulus: LZ_SUPPRESS=0, value=16'h0050. Required: all four digits lit.
- Blank and dp:
  - Stimulus: dp_in=4'b0010, blank_in=4'b0100, value=16'h8888.
  - Required: digit1 has dp=0; digit2 has ca=1111111 and dp=1; digits 0 and 3 have ca=0000000 and dp=1.
- Tear-free load:
  - Stimulus: pulse load with value=16'hFFFF on a tick edge while 16'h0000 is shown.
  - Required: no digit shows a mixed pattern; all digits read F from the next digit onward.
  - Stimulus: change value without load. Required: display unchanged.
- Width sweep:
  - Stimulus: NUM_DIGITS=1 and NUM_DIGITS=8 builds.
  - Required: digit_idx wraps at 0 and at 7 respectively; an stays one-hot-zero throughout.
